pwm_soft_start_sequencer: RTL and testbench
===========================================

// Module: pwm_soft_start_sequencer
// PURPOSE
// Run-time controller for the PWM generator. Holds the clock_step and fb_interval
// configuration written by the UART-to-I2C bridge register file. Sequences start-up:
// ramps clock_step from a low value up to the target (soft start), then regulates.
// Watches the filtered comparator feedback and latches a fault if regulation is lost.
// PARAMETERS
// STEP_START   16'd512    clock_step value loaded at the beginning of soft start
// RAMP_DIV     1024       clock cycles between soft-start increments (>=1)
// RAMP_INC     16'd64     clock_step increment per soft-start tick
// FB_TIMEOUT   2**20      consecutive cycles of fb_low in REGULATE that raise a fault
// PORTS
// clock        in   1   system clock, sole clock domain
// reset        in   1   asynchronous, active-high reset
// cfg_wr       in   1   single-cycle config write strobe from bridge register file
// cfg_addr     in   2   0=target_step, 1=fb_interval, 2=control (bit0 run, bit1 fault_clr)
// cfg_data     in   16  write data
// fb_filt      in   1   filtered comparator output from generator (1 = output above ref)
// clock_step   out  16  to generator: phase-accumulator increment
// fb_interval  out  16  to generator: duty adjust hysteresis
// pwm_en       out  1   gates generator output stage; 0 forces power stage off
// state_o      out  2   current FSM state encoding (status readback)
// fault        out  1   sticky fault flag
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high.
// - Reset values: clock_step=0, fb_interval=16'd100, pwm_en=0, state_o=IDLE, fault=0.
//   Internal: target_step=16'd16384, run=0, ramp counter=0, timeout counter=0.
// - Config writes take effect the cycle after cfg_wr.
//   - addr 0 updates target_step.
//   - addr 1 updates fb_interval and drives it to the output directly.
//   - addr 2: bit0 sets run; bit1=1 clears fault (self-clearing pulse, not stored).
//   - addr 3 is ignored.
// - FSM states (state_o encoding): IDLE=0, RAMP=1, REGULATE=2, FAULT=3.
//   - IDLE: pwm_en=0, clock_step=0. If run=1 and fault=0, go to RAMP next cycle and
//     load clock_step=STEP_START.
//   - RAMP: pwm_en=1. Every RAMP_DIV cycles, clock_step += RAMP_INC, saturating at
//     target_step. The computation is 17-bit: clamp when sum > target_step or the
//     carry is set. Once clock_step==target_step, go to REGULATE. If STEP_START >=
//     target_step, load target_step directly and skip to REGULATE one cycle later.
//   - REGULATE: pwm_en=1, clock_step tracks target_step on any later write
//     (no re-ramp). The timeout counter increments while fb_filt=0 and resets to 0
//     when fb_filt=1. At count == FB_TIMEOUT-1 with fb_filt=0, set fault and go to
//     FAULT.
//   - FAULT: pwm_en=0 and clock_step=0 in the same cycle as the transition (registered
//     outputs updated on entry). Stay in FAULT until a fault_clr write arrives; it
//     clears fault and returns to IDLE. run stays set, so restart follows automatically.
//   - run=0 written in RAMP or REGULATE: next state IDLE, pwm_en=0 on that edge.
// - Priority on the same cycle: reset > fault detection > run=0 > fault_clr > ramp tick.
//   A fault_clr written while not in FAULT is a no-op.
// - Counters saturate and never wrap. The ramp counter resets to 0 on every RAMP entry.
// - Asserting reset mid-ramp returns every output to its reset value immediately
//   (asynchronously).
// - fb_filt is already synchronous to clock; no synchronizer is needed here.
// STRUCTURE
// - Shared package pwm_ctrl_pkg: the state enum {IDLE,RAMP,REGULATE,FAULT} (2-bit),
//   cfg address constants, and reset defaults for target_step and fb_interval.
//   The bridge register file reuses these.
// - One sub-module: pwm_ramp_unit. Contains the tick divider plus the saturating
//   adder. Inputs: start, load_val, target. Outputs: step, done.
// - The FSM and config registers stay in the top module.
// TESTING (bench uses RAMP_DIV=4, FB_TIMEOUT=16, STEP_START=100, RAMP_INC=50)
// 1. Reset then idle -> clock_step=0, pwm_en=0, state_o=0, fb_interval=100.
// 2. Write target=300, then run=1 -> clock_step goes 100,150,200,250,300, one step
//    every 4 cycles; state_o=2 the cycle after 300; pwm_en=1 throughout.
// 3. Write target=320 -> ramp clamps: 300 is followed by 320, not 350. Repeat with
//    target=16'hFFF0 and RAMP_INC=16'h0100: no wrap, ends at FFF0.
// 4. REGULATE with fb_filt held 0 for 16 cycles -> fault=1, state_o=3, pwm_en=0,
//    clock_step=0. fb_filt=1 at cycle 15 instead -> no fault.
// 5. In FAULT, write fault_clr -> fault=0, IDLE, then RAMP restarts from 100.
//    Write run=0 mid-ramp -> IDLE, pwm_en=0 on the next edge.
// 6. Assert reset mid-ramp between clock edges -> all outputs return to reset values
//    before the next edge; target_step returns to 16384.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM control path: FSM state encoding, config register
// map and reset defaults. The bridge register file imports this package as well.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAMP     = 2'd1,
    ST_REGULATE = 2'd2,
    ST_FAULT    = 2'd3
  } pwm_state_t;

  localparam logic [1:0] CFG_ADDR_TARGET      = 2'd0;
  localparam logic [1:0] CFG_ADDR_FB_INTERVAL = 2'd1;
  localparam logic [1:0] CFG_ADDR_CONTROL     = 2'd2;

  localparam int CTRL_RUN_BIT       = 0;
  localparam int CTRL_FAULT_CLR_BIT = 1;

  localparam logic [15:0] TARGET_STEP_RST = 16'd16384;
  localparam logic [15:0] FB_INTERVAL_RST = 16'd100;

  // 17-bit add so a carry out of bit 15 clamps instead of wrapping to a small step.
  function automatic logic [15:0] sat_add(input logic [15:0] base,
                                          input logic [15:0] inc,
                                          input logic [15:0] limit);
    logic [16:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum[16] || (sum[15:0] > limit)) return limit;
    return sum[15:0];
  endfunction

endpackage

// File: rtl/pwm_soft_start_sequencer_if.sv
// Config/feedback inputs and generator-control outputs of the soft-start sequencer.
// master = register file / feedback side, slave = sequencer.
interface pwm_soft_start_sequencer_if;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        fb_filt;
  logic [15:0] clock_step;
  logic [15:0] fb_interval;
  logic        pwm_en;
  logic [1:0]  state_o;
  logic        fault;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, fb_filt,
    input  clock_step, fb_interval, pwm_en, state_o, fault
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, fb_filt,
    output clock_step, fb_interval, pwm_en, state_o, fault
  );
endinterface

// File: rtl/pwm_ramp_unit.sv
// Soft-start datapath: tick divider plus saturating step adder. Produces the next
// clock_step value from the current one; the owning FSM decides when to take it.
module pwm_ramp_unit
  import pwm_ctrl_pkg::*;
#(
  parameter int          RAMP_DIV = 1024,
  parameter logic [15:0] RAMP_INC = 16'd64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        active,
  input  logic [15:0] load_val,
  input  logic [15:0] target,
  input  logic [15:0] cur,
  output logic [15:0] step,
  output logic        done
);

  localparam int               DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = active && (div_cnt == DIV_LAST);

  // Cleared on RAMP entry and outside RAMP so every ramp starts a full interval.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (start || !active || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // NOTE: every branch assigns step, so this stays combinational with no latch.
  always_comb begin
    if (start) begin
      step = (load_val >= target) ? target : load_val;
    end else if (tick) begin
      step = sat_add(cur, RAMP_INC, target);
    end else begin
      step = cur;
    end
  end

  assign done = (cur == target);

endmodule

// File: rtl/pwm_soft_start_sequencer.sv
// Run-time controller for the PWM generator: config registers, soft-start ramp,
// regulation with feedback-loss timeout, and a sticky fault latch.
module pwm_soft_start_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter logic [15:0] STEP_START = 16'd512,
  parameter int          RAMP_DIV   = 1024,
  parameter logic [15:0] RAMP_INC   = 16'd64,
  parameter int          FB_TIMEOUT = 2**20
) (
  input  logic                         clock,
  input  logic                         reset,
  pwm_soft_start_sequencer_if.slave    bus
);

  localparam int              TO_W    = (FB_TIMEOUT > 1) ? $clog2(FB_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FB_TIMEOUT - 1);

  pwm_state_t      state;
  logic [15:0]     target_step;
  logic [15:0]     fb_interval;
  logic [15:0]     clock_step;
  logic            run;
  logic            pwm_en;
  logic            fault;
  logic [TO_W-1:0] to_cnt;

  logic        wr_target, wr_interval, wr_ctrl;
  logic        run_stop, fault_clr, fb_expired;
  logic        ramp_start, ramp_done;
  logic [15:0] ramp_step;

  assign wr_target   = bus.cfg_wr && (bus.cfg_addr == CFG_ADDR_TARGET);
  assign wr_interval = bus.cfg_wr && (bus.cfg_addr == CFG_ADDR_FB_INTERVAL);
  assign wr_ctrl     = bus.cfg_wr && (bus.cfg_addr == CFG_ADDR_CONTROL);
  assign run_stop    = wr_ctrl && !bus.cfg_data[CTRL_RUN_BIT];
  assign fault_clr   = wr_ctrl && bus.cfg_data[CTRL_FAULT_CLR_BIT];
  assign fb_expired  = !bus.fb_filt && (to_cnt == TO_LAST);
  assign ramp_start  = (state == ST_IDLE) && run && !fault;

  pwm_ramp_unit #(
    .RAMP_DIV (RAMP_DIV),
    .RAMP_INC (RAMP_INC)
  ) u_ramp (
    .clock    (clock),
    .reset    (reset),
    .start    (ramp_start),
    .active   (state == ST_RAMP),
    .load_val (STEP_START),
    .target   (target_step),
    .cur      (clock_step),
    .step     (ramp_step),
    .done     (ramp_done)
  );

  // NOTE: registers use <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target_step <= TARGET_STEP_RST;
      fb_interval <= FB_INTERVAL_RST;
      run         <= 1'b0;
    end else begin
      if (wr_target)   target_step <= bus.cfg_data;
      if (wr_interval) fb_interval <= bus.cfg_data;
      if (wr_ctrl)     run         <= bus.cfg_data[CTRL_RUN_BIT];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      clock_step <= '0;
      pwm_en     <= 1'b0;
      fault      <= 1'b0;
      to_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (ramp_start) begin
            state      <= ST_RAMP;
            clock_step <= ramp_step;
            pwm_en     <= 1'b1;
          end
        end
        ST_RAMP: begin
          if (run_stop || !run) begin
            state      <= ST_IDLE;
            clock_step <= '0;
            pwm_en     <= 1'b0;
          end else begin
            clock_step <= ramp_step;
            if (ramp_done) state <= ST_REGULATE;
          end
        end
        ST_REGULATE: begin
          // Loss of regulation outranks a simultaneous stop request.
          if (fb_expired) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            clock_step <= '0;
            pwm_en     <= 1'b0;
            to_cnt     <= '0;
          end else if (run_stop || !run) begin
            state      <= ST_IDLE;
            clock_step <= '0;
            pwm_en     <= 1'b0;
            to_cnt     <= '0;
          end else begin
            clock_step <= target_step;
            to_cnt     <= bus.fb_filt ? '0 : to_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state <= ST_IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.clock_step  = clock_step;
  assign bus.fb_interval = fb_interval;
  assign bus.pwm_en      = pwm_en;
  assign bus.state_o     = state;
  assign bus.fault       = fault;

endmodule

// File: tb/tb_pwm_soft_start_sequencer.sv
// Scoreboard bench: stimulus queues the expected output tuple and edge number for
// each output change; a per-lane monitor pops and compares whenever outputs change.
module tb_pwm_soft_start_sequencer;

  localparam int DIV = 4;

  typedef struct packed {
    logic [15:0] step;
    logic [15:0] intv;
    logic        pwm;
    logic [1:0]  st;
    logic        flt;
  } obs_t;

  typedef struct {
    obs_t  o;
    int    at;
    string tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        exp_q [2][$];
  logic [1:0]  cfg_wr_v = '0;
  logic [1:0]  fb_v     = '1;
  logic [1:0]  cfg_addr_v [2];
  logic [15:0] cfg_data_v [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Lane 0 ramps by 50, lane 1 by 0x100 to exercise the carry clamp.
  for (genvar g = 0; g < 2; g++) begin : lane
    pwm_soft_start_sequencer_if bus ();
    assign bus.cfg_wr   = cfg_wr_v[g];
    assign bus.cfg_addr = cfg_addr_v[g];
    assign bus.cfg_data = cfg_data_v[g];
    assign bus.fb_filt  = fb_v[g];

    pwm_soft_start_sequencer #(
      .STEP_START (16'd100),
      .RAMP_DIV   (DIV),
      .RAMP_INC   ((g == 0) ? 16'd50 : 16'h0100),
      .FB_TIMEOUT (16)
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );

    initial begin : mon
      obs_t prev, cur;
      exp_t e;
      bit   first;
      first = 1'b1;
      prev  = '0;
      forever begin
        @(negedge clock);
        cur = {bus.clock_step, bus.fb_interval, bus.pwm_en, bus.state_o, bus.fault};
        if (first || (cur != prev)) begin
          if (exp_q[g].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL lane%0d unexpected_change got=%h at cycle %0d", g, cur, cyc);
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("lane%0d %s", g, e.tag), 64'(cur), 64'(e.o));
            if (e.at >= 0) check($sformatf("lane%0d %s cycle", g, e.tag), 64'(cyc), 64'(e.at));
          end
        end
        prev  = cur;
        first = 1'b0;
      end
    end
  end

  function automatic obs_t mk(input int s, input int iv, input bit p, input int st, input bit f);
    mk = {16'(s), 16'(iv), p, 2'(st), f};
  endfunction

  task automatic push_exp(input int l, input string tag, input obs_t o, input int at);
    exp_t e;
    e.o   = o;
    e.at  = at;
    e.tag = tag;
    exp_q[l].push_back(e);
  endtask

  // Expected soft-start trajectory entering RAMP at edge e, optionally truncated.
  task automatic push_ramp(input int l, input int e, input int start, input int inc,
                           input int tgt, input int iv, input int max_items);
    int v, t, n;
    v = (start >= tgt) ? tgt : start;
    t = e;
    push_exp(l, $sformatf("ramp_%0d", v), mk(v, iv, 1, 1, 0), t);
    n = 1;
    while ((v != tgt) && (n < max_items)) begin
      v = v + inc;
      if (v > tgt) v = tgt;
      t += DIV;
      push_exp(l, $sformatf("ramp_%0d", v), mk(v, iv, 1, 1, 0), t);
      n++;
    end
    if (v == tgt) push_exp(l, "regulate", mk(tgt, iv, 1, 2, 0), t + 1);
  endtask

  // Called at a negedge; the write is captured on the following edge.
  task automatic wr(input int l, input logic [1:0] a, input logic [15:0] d);
    cfg_addr_v[l] = a;
    cfg_data_v[l] = d;
    cfg_wr_v[l]   = 1'b1;
    @(negedge clock);
    cfg_wr_v[l]   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (((exp_q[0].size() != 0) || (exp_q[1].size() != 0)) && (n < budget)) begin
      @(negedge clock);
      n++;
    end
    if ((exp_q[0].size() != 0) || (exp_q[1].size() != 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d/%0d after %0d cycles",
               exp_q[0].size(), exp_q[1].size(), n);
      exp_q[0].delete();
      exp_q[1].delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e;
    cfg_addr_v[0] = '0; cfg_addr_v[1] = '0;
    cfg_data_v[0] = '0; cfg_data_v[1] = '0;
    push_exp(0, "reset", mk(0, 100, 0, 0, 0), -1);
    push_exp(1, "reset", mk(0, 100, 0, 0, 0), -1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // fb_interval write; ignored address and idle fault_clr change nothing.
    c = cyc;
    push_exp(0, "fb_interval", mk(0, 200, 0, 0, 0), c + 1);
    wr(0, 2'd1, 16'd200);
    wr(0, 2'd3, 16'h1234);
    wr(0, 2'd2, 16'h0002);
    repeat (3) @(negedge clock);

    // Ramp to 300, then track a new target without re-ramping.
    wr(0, 2'd0, 16'd300);
    c = cyc;
    push_ramp(0, c + 2, 100, 50, 300, 200, 1000);
    wr(0, 2'd2, 16'd1);
    drain(100);
    c = cyc;
    push_exp(0, "track_320", mk(320, 200, 1, 2, 0), c + 2);
    wr(0, 2'd0, 16'd320);
    drain(10);

    // 14 low samples then high: counter restarts, no fault.
    fb_v[0] = 1'b0;
    repeat (14) @(negedge clock);
    fb_v[0] = 1'b1;
    repeat (20) @(negedge clock);
    check("no_fault_flag", 64'(lane[0].bus.fault), 64'd0);
    check("no_fault_state", 64'(lane[0].bus.state_o), 64'd2);

    // 16 low samples: fault on the 16th edge.
    c = cyc;
    fb_v[0] = 1'b0;
    push_exp(0, "fault", mk(0, 200, 0, 3, 1), c + 16);
    drain(40);

    // Clear fault with run kept set: restart ramps to 320 (300 then 320).
    c = cyc;
    push_exp(0, "fault_clr", mk(0, 200, 0, 0, 0), c + 1);
    push_ramp(0, c + 2, 100, 50, 320, 200, 1000);
    wr(0, 2'd2, 16'd3);
    fb_v[0] = 1'b1;
    drain(100);

    // Stop from REGULATE, then stop mid-ramp on a tick edge (stop wins).
    c = cyc;
    push_exp(0, "stop_regulate", mk(0, 200, 0, 0, 0), c + 1);
    wr(0, 2'd2, 16'd0);
    c = cyc;
    e = c + 2;
    push_ramp(0, e, 100, 50, 320, 200, 3);
    push_exp(0, "stop_ramp", mk(0, 200, 0, 0, 0), e + 3 * DIV);
    wr(0, 2'd2, 16'd1);
    while (cyc < e + 3 * DIV - 1) @(negedge clock);
    wr(0, 2'd2, 16'd0);
    drain(20);

    // Lane 1: STEP_START above target skips straight to REGULATE.
    wr(1, 2'd0, 16'd80);
    c = cyc;
    push_ramp(1, c + 2, 100, 256, 80, 100, 1000);
    wr(1, 2'd2, 16'd1);
    drain(20);
    c = cyc;
    push_exp(1, "stop", mk(0, 100, 0, 0, 0), c + 1);
    wr(1, 2'd2, 16'd0);

    // Lane 1: large increment near the top of range clamps at FFF0 without wrapping.
    wr(1, 2'd0, 16'hFFF0);
    c = cyc;
    push_ramp(1, c + 2, 100, 256, 16'hFFF0, 100, 1000);
    wr(1, 2'd2, 16'd1);
    drain(1100);

    // Asynchronous reset between edges in the middle of a lane 0 ramp.
    c = cyc;
    e = c + 2;
    push_ramp(0, e, 100, 50, 320, 200, 2);
    wr(0, 2'd2, 16'd1);
    while (cyc < e + 5) @(negedge clock);
    drain(5);
    @(posedge clock);
    #2;
    push_exp(0, "async_reset", mk(0, 100, 0, 0, 0), cyc);
    push_exp(1, "async_reset", mk(0, 100, 0, 0, 0), cyc);
    reset = 1'b1;
    #1;
    check("async_reset_step", 64'(lane[0].bus.clock_step), 64'd0);
    check("async_reset_pwm_en", 64'(lane[0].bus.pwm_en), 64'd0);
    check("async_reset_state", 64'(lane[0].bus.state_o), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    drain(5);

    // Default target after reset is 16384: full ramp ends there.
    c = cyc;
    push_ramp(0, c + 2, 100, 50, 16384, 100, 1000);
    wr(0, 2'd2, 16'd1);
    drain(1400);
    repeat (5) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
